// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time program loader.
package cpu_pkg;

  // Loader sequencing: wait, read the length header, collect a byte, write it, release the cpu.
  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    WRITE,
    RUN
  } loader_state_e;

  // Depth of every input synchroniser chain.
  localparam int LOADER_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a rising-edge detector on the synchronised level.
module sync_edge
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [LOADER_SYNC_STAGES-1:0] sync_q;
  logic                          prev_q;

  // Shift the asynchronous input through the chain and remember the last synced level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[LOADER_SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[LOADER_SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[LOADER_SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed program over a two-wire serial link,
// writes it into cpu memory and keeps the cpu in reset until the load finishes.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ser_clk,
  input  logic                  ser_data,
  input  logic                  load_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic ser_lvl;
  logic ser_rise;
  logic load_lvl;
  logic load_rise;

  sync_edge u_ser_clk_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .async_i (ser_clk),
    .level_o (ser_lvl),
    .rise_o  (ser_rise)
  );

  sync_edge u_load_req_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .async_i (load_req),
    .level_o (load_lvl),
    .rise_o  (load_rise)
  );

  logic [LOADER_SYNC_STAGES-1:0] data_sync_q;
  logic [DATA_WIDTH-2:0]         shift_q;
  logic [CNT_W-1:0]              bit_cnt_q;
  logic [ADDR_WIDTH-1:0]         remaining_q;
  logic [ADDR_WIDTH-1:0]         mem_addr_q;
  logic [DATA_WIDTH-1:0]         mem_wdata_q;
  logic [1:0]                    prime_q;
  logic                          done_q;
  logic                          error_q;
  loader_state_e                 state_q;

  logic                  data_lvl;
  logic                  bit_stb;
  logic                  frame_done;
  logic                  primed;
  logic                  in_load;
  logic [DATA_WIDTH-1:0] frame_w;

  assign data_lvl   = data_sync_q[LOADER_SYNC_STAGES-1];
  // A rise pulse always coincides with a high level; the level term only documents that.
  assign bit_stb    = ser_rise & ser_lvl;
  assign frame_w    = {shift_q, data_lvl};
  assign frame_done = bit_stb && (bit_cnt_q == LAST_BIT);
  assign primed     = (prime_q == 2'(LOADER_SYNC_STAGES));
  assign in_load    = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == WRITE);

  // Serial data only needs a synchronised level; bit timing comes from ser_clk.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_sync_q <= '0;
    end else begin
      data_sync_q <= {data_sync_q[LOADER_SYNC_STAGES-2:0], ser_data};
    end
  end

  // Loader FSM: after reset it waits for the load_req synchroniser to fill before deciding,
  // then collects frames, writes payload bytes and finally releases the cpu.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      prime_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (!primed) begin
        prime_q <= prime_q + 2'd1;
      end

      if (in_load && bit_stb) begin
        shift_q   <= frame_w[DATA_WIDTH-2:0];
        bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (primed) begin
            if (load_lvl) begin
              state_q   <= HEADER;
              error_q   <= 1'b0;
              done_q    <= 1'b0;
              shift_q   <= '0;
              bit_cnt_q <= '0;
            end else begin
              state_q <= RUN;
            end
          end
        end

        HEADER: begin
          if (!load_lvl) begin
            state_q   <= IDLE;
            error_q   <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end else if (frame_done) begin
            remaining_q <= ADDR_WIDTH'(frame_w);
            mem_addr_q  <= '0;
            if (frame_w == '0) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (!load_lvl) begin
            state_q   <= IDLE;
            error_q   <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end else if (frame_done) begin
            mem_wdata_q <= frame_w;
            state_q     <= WRITE;
          end
        end

        WRITE: begin
          if (!load_lvl) begin
            state_q   <= IDLE;
            error_q   <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end else begin
            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - ADDR_WIDTH'(1);
            if (remaining_q == ADDR_WIDTH'(1)) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= PAYLOAD;
            end
          end
        end

        RUN: begin
          if (load_rise) begin
            state_q   <= HEADER;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The strobe is suppressed when an abort lands on the write cycle.
  assign mem_we    = (state_q == WRITE) && load_lvl;
  assign cpu_reset = (state_q != RUN);
  assign busy      = in_load;
  assign done      = done_q;
  assign error     = error_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader that sits directly upstream of the cpu core and its memory. It receives a program over a slow two-wire serial link from the Tiny Tapeout input pins and writes it byte by byte into cpu memory through a dedicated write port. The cpu is held in reset for the whole load and released when the load completes. When no load is requested, the cpu is released immediately after reset.

Parameters:
ADDR_WIDTH, 8, memory address width; also the width of the length header.
DATA_WIDTH, 8, memory word width; also the serial frame size in bits.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
ser_clk  in  1  external shift clock, asynchronous to clock
ser_data  in  1  serial data, MSB first, sampled on the synchronised rising edge of ser_clk
load_req  in  1  level, asynchronous; high requests a load, low during a load aborts it
mem_addr  out  ADDR_WIDTH  write address into cpu memory
mem_wdata  out  DATA_WIDTH  write data into cpu memory
mem_we  out  1  one-cycle write strobe
cpu_reset  out  1  holds the cpu core in reset
busy  out  1  high in HEADER/PAYLOAD/WRITE
done  out  1  high in RUN after a successful load; cleared on entry to HEADER or IDLE
error  out  1  sticky abort flag; cleared on entry to HEADER

Behaviour:
- Synchronisers: ser_clk, ser_data and load_req each pass through 2 flops. A rising-edge detect on the synchronised ser_clk gives the one-cycle pulse bit_stb.
  - bit_stb fires 3 clocks after the pin edge.
  - ser_data is taken from its synchroniser in the same cycle as bit_stb.
  - External requirement: ser_clk high and low phases are each at least 4 clocks; ser_data is stable for 3 clocks around the ser_clk rise.
- Shift register and bit counter: 3-bit counter (width clog2(DATA_WIDTH)). On bit_stb the register shifts left and inserts ser_data. A frame completes on the DATA_WIDTH-th bit_stb; the counter then wraps to 0.
- States (loader_state_e): IDLE, HEADER, PAYLOAD, WRITE, RUN.
  - IDLE: cpu_reset=1. Next cycle goes to HEADER if synced load_req=1, else RUN.
  - HEADER: on frame complete, latch remaining = frame and set mem_addr = 0. Go to RUN with done=1 if frame == 0, else PAYLOAD.
  - PAYLOAD: on frame complete, mem_wdata = frame, then go to WRITE.
  - WRITE (1 cycle): mem_we=1 at the current mem_addr. Then mem_addr += 1 (wraps mod 2^ADDR_WIDTH) and remaining -= 1. Go to RUN with done=1 if remaining was 1, else PAYLOAD.
  - RUN: cpu_reset=0. A rising edge of synced load_req goes to HEADER. cpu_reset re-asserts combinationally in HEADER.
- Abort: synced load_req=0 in HEADER, PAYLOAD or WRITE sets error=1 and goes to IDLE, which then moves to RUN. Already-written bytes remain in memory.
  - Abort has priority over a simultaneous frame completion or WRITE, so no strobe is issued that cycle.
- Bit counter and shift register clear on entry to HEADER and on abort.
- Reset values: state IDLE, cpu_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, all counters and synchronisers 0.
- Reset mid-load: everything returns to reset values immediately. Partial memory contents are neither cleared nor rewritten.
- Extra ser_clk edges in RUN or IDLE are ignored.
- mem_we is never asserted outside WRITE.
- Length header 0xFF loads 255 bytes (addresses 0..254); a 256-byte load is not supported.

Decomposition:
- Shared package (cpu_pkg): loader_state_e and LOADER_SYNC_STAGES = 2.
- Sub-module sync_edge: a 2-flop synchroniser plus rising-edge detector, with an asynchronous active-high reset. Outputs the synced level and a rise pulse.
  - One instance each for ser_clk and load_req.
  - ser_data uses the level output only.

Test Plan:
- load_req=1, serial frames 0x03, 0xA5, 0x3C, 0xFF -> exactly three mem_we pulses at addresses 0/1/2 with data A5/3C/FF; cpu_reset then falls, done=1, error=0.
- load_req held low from reset -> cpu_reset falls 3 clocks after reset deassertion; mem_we never asserts; done=0.
- Header 0x00 -> no writes; RUN with done=1 after the eighth bit.
- Header 0x04, two payload bytes, then load_req=0 -> writes at addresses 0 and 1 only; error=1; cpu_reset falls.
  - A following load clears error and restarts at address 0.
- Reset pulsed during the 5th bit of payload byte 2 -> all outputs return to reset values within the same clock (asynchronous); no further mem_we.
- From RUN after a load, raise load_req again and send 0x01, 0x7E -> cpu_reset rises, one write of 0x7E at address 0, done=1 again.
